// File: rtl/simple_proc_exec.sv
// Multi-cycle 16-bit processor core: IDLE/FETCH/DECODE/EXEC(/MEM/WB) over an 8x16 register file
// and a private data RAM. Define SIMPLE_PROC_MUL_EN to turn opcode 0 into MUL instead of NOP.
module simple_proc_exec #(
  parameter int PC_W     = 10,
  parameter int DMEM_AW  = 10,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [15:0]     data_in,
  input  logic            data_vld,
  output logic [15:0]     result,
  output logic            zero,
  output logic            negative,
  output logic            overflow,
  output logic            carry,
  output logic            store_loaded_val,
  output logic [PC_W-1:0] pc,
  output logic            ram_read_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_HALT = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_BZ   = 4'hE;
  localparam logic [3:0] OP_MOV  = 4'hF;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       regs_q [8];
  logic [15:0]       regs_d [8];
  logic [15:0]       result_q, result_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

  logic [15:0]       dmem [2**DMEM_AW];
  logic [15:0]       mem_rdata_q;
  logic              dmem_we;

  logic [3:0]        op;
  logic [2:0]        rd_idx, rs_idx, rt_idx;
  logic [15:0]       rd_val, rs_val, rt_val;
  logic signed [15:0] imm_s;
  logic [DMEM_AW-1:0] dm_addr;
  logic [16:0]       sum;
  logic [15:0]       wdata;
  logic              rf_we, upd_zn;

  function automatic logic [16:0] add16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
  endfunction

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic ovf16(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] s);
    return (a[15] == b[15]) && (s[15] != a[15]);
  endfunction

  assign op      = ir_q[15:12];
  assign rd_idx  = ir_q[11:9];
  assign rs_idx  = ir_q[8:6];
  assign rt_idx  = ir_q[5:3];
  assign rd_val  = regs_q[rd_idx];
  assign rs_val  = regs_q[rs_idx];
  assign rt_val  = regs_q[rt_idx];
  assign imm_s   = {{7{ir_q[8]}}, ir_q[8:0]};
  assign dm_addr = rs_val[DMEM_AW-1:0];

`ifdef SIMPLE_PROC_MUL_EN
  logic [31:0] prod;
  assign prod = 32'(rs_val) * 32'(rt_val);
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    regs_d   = regs_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    sum      = '0;
    wdata    = '0;
    rf_we    = 1'b0;
    upd_zn   = 1'b0;
    dmem_we  = 1'b0;

    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (data_vld) begin
          ir_d    = data_in;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_W'(1);
        case (op)
`ifdef SIMPLE_PROC_MUL_EN
          OP_NOP: begin
            wdata = prod[15:0]; rf_we = 1'b1; upd_zn = 1'b1;
            c_d = |prod[31:16]; v_d = 1'b0;
          end
`else
          OP_NOP: begin end
`endif
          OP_ADD: begin
            sum   = add16(rs_val, rt_val, 1'b0);
            wdata = sum[15:0]; rf_we = 1'b1; upd_zn = 1'b1;
            c_d = sum[16]; v_d = ovf16(rs_val, rt_val, sum[15:0]);
          end
          // Subtract as rs + ~rt + 1 so carry-out doubles as "no borrow".
          OP_SUB: begin
            sum   = add16(rs_val, ~rt_val, 1'b1);
            wdata = sum[15:0]; rf_we = 1'b1; upd_zn = 1'b1;
            c_d = sum[16]; v_d = ovf16(rs_val, ~rt_val, sum[15:0]);
          end
          OP_HALT: begin
            state_d = S_HALTED;
            pc_d    = pc_q;
          end
          OP_AND: begin wdata = rs_val & rt_val; rf_we = 1'b1; upd_zn = 1'b1; c_d = 1'b0; v_d = 1'b0; end
          OP_OR:  begin wdata = rs_val | rt_val; rf_we = 1'b1; upd_zn = 1'b1; c_d = 1'b0; v_d = 1'b0; end
          OP_XOR: begin wdata = rs_val ^ rt_val; rf_we = 1'b1; upd_zn = 1'b1; c_d = 1'b0; v_d = 1'b0; end
          OP_NOT: begin wdata = ~rs_val;         rf_we = 1'b1; upd_zn = 1'b1; c_d = 1'b0; v_d = 1'b0; end
          OP_SHL: begin wdata = {rs_val[14:0], 1'b0}; rf_we = 1'b1; upd_zn = 1'b1; c_d = rs_val[15]; v_d = 1'b0; end
          OP_SHR: begin wdata = {1'b0, rs_val[15:1]}; rf_we = 1'b1; upd_zn = 1'b1; c_d = rs_val[0];  v_d = 1'b0; end
          OP_LDI: begin wdata = imm_s; rf_we = 1'b1; upd_zn = 1'b1; end
          OP_LD: begin
            state_d = S_MEM;
            pc_d    = pc_q;
          end
          OP_ST:  dmem_we = 1'b1;
          OP_JMP: pc_d = PC_W'(ir_q[9:0]);
          OP_BZ:  if (z_q) pc_d = PC_W'(ir_q[9:0]);
          OP_MOV: begin wdata = rs_val; rf_we = 1'b1; upd_zn = 1'b1; end
          default: begin end
        endcase
      end
      S_MEM: state_d = S_WB;
      S_WB: begin
        wdata   = mem_rdata_q;
        rf_we   = 1'b1;
        upd_zn  = 1'b1;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    if (upd_zn) begin
      z_d = (wdata == 16'd0);
      n_d = wdata[15];
    end
    if (rf_we) begin
      regs_d[rd_idx] = wdata;
      result_d       = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_W'(RESET_PC);
      ir_q     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      regs_q   <= regs_d;
    end
  end

  // Data RAM keeps its contents across reset; the write strobe only exists in EXEC.
  always_ff @(posedge clk) begin
    if (dmem_we) dmem[dm_addr] <= rd_val;
    if (state_q == S_MEM) mem_rdata_q <= dmem[dm_addr];
  end

  assign pc               = pc_q;
  assign ram_read_en      = (state_q == S_FETCH);
  assign store_loaded_val = (state_q == S_WB);
  assign result           = result_q;
  assign zero             = z_q;
  assign negative         = n_q;
  assign carry            = c_q;
  assign overflow         = v_q;

endmodule

// File: tb/tb_simple_proc_exec.sv
// Directed bench for simple_proc_exec: a table of small programs with expected final state,
// plus hand sequences for reset behaviour, mid-instruction reset and a stalled DECODE.
module tb_simple_proc_exec;

  localparam logic [15:0] H = 16'h3C00;

  logic        clk, rst_n, start, data_vld;
  logic [15:0] data_in, result;
  logic        zero, negative, overflow, carry, store_loaded_val, ram_read_en;
  logic [9:0]  pc;

  logic [15:0] prog [1024];
  logic        pend, block;
  int          total, bad, slv_cnt;

  simple_proc_exec #(.PC_W(10), .DMEM_AW(10), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .data_vld(data_vld),
    .result(result), .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
    .store_loaded_val(store_loaded_val), .pc(pc), .ram_read_en(ram_read_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program RAM: word for the current pc arrives one cycle later; valid held until consumed.
  always @(posedge clk) data_in <= prog[pc];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pend <= 1'b0;
    else if (ram_read_en) pend <= 1'b1;
    else if (data_vld)    pend <= 1'b0;
  end
  assign data_vld = pend & ~block;

  typedef struct {
    logic [0:7][15:0] w;
    logic             xv;
    logic [9:0]       xa;
    logic [15:0]      xw;
    logic [15:0]      er;
    logic [3:0]       ef;   // {Z,N,C,V}
    logic [9:0]       epc;
    int               eslv;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic load_reset(input vec_t v);
    rst_n = 1'b0; start = 1'b0; block = 1'b0;
    for (int i = 0; i < 1024; i++) prog[i] = H;
    for (int i = 0; i < 8; i++) prog[i] = v.w[i];
    if (v.xv) prog[v.xa] = v.xw;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic run_to_halt(output logic to);
    int idle, cyc;
    idle = 0; cyc = 0; slv_cnt = 0;
    start = 1'b1;
    while (idle < 12 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (ram_read_en) idle = 0; else idle++;
      if (store_loaded_val) slv_cnt++;
    end
    to = (cyc >= 2000);
  endtask

  initial begin
    logic to;
    int   k, fetches;
    total = 0; bad = 0; slv_cnt = 0;
    rst_n = 1'b0; start = 1'b0; block = 1'b0;

    //               program words                                                          xv   xa      xw        result    ZNCV    pc     slv
    vt[0]  = '{{16'hA205,16'hA403,16'h1650,H,H,H,H,H},                                       1'b0,10'h0,  16'h0,    16'h0008, 4'b0000,10'h003,0};
    vt[1]  = '{{16'hA2FF,16'hA5FF,16'h1650,H,H,H,H,H},                                       1'b0,10'h0,  16'h0,    16'h00FE, 4'b0010,10'h003,0};
    vt[2]  = '{{16'hA2FF,16'hA5FF,16'h1650,16'h2848,H,H,H,H},                                1'b0,10'h0,  16'h0,    16'h0000, 4'b1010,10'h004,0};
    vt[3]  = '{{16'hA3FF,16'h9240,16'h1448,H,H,H,H,H},                                       1'b0,10'h0,  16'h0,    16'hFFFE, 4'b0101,10'h003,0};
    vt[4]  = '{{16'hA20A,16'hA455,16'hC440,16'hA20B,16'hC240,16'hA20A,16'hB640,H},           1'b0,10'h0,  16'h0,    16'h0055, 4'b0000,10'h007,1};
    vt[5]  = '{{16'h2000,16'hE020,H,H,H,H,H,H},                                              1'b1,10'h020,16'hAA77, 16'h0077, 4'b0010,10'h021,0};
    vt[6]  = '{{16'hA2F0,16'hA43C,16'h4650,16'h58C8,16'h6B10,16'h7D40,H,H},                  1'b0,10'h0,  16'h0,    16'hFF33, 4'b0100,10'h006,0};
    vt[7]  = '{{16'hA300,16'h8440,16'hF680,H,H,H,H,H},                                       1'b0,10'h0,  16'h0,    16'hFE00, 4'b0110,10'h003,0};
    vt[8]  = '{{16'hA201,16'hA402,16'h2650,H,H,H,H,H},                                       1'b0,10'h0,  16'h0,    16'hFFFF, 4'b0100,10'h003,0};
`ifdef SIMPLE_PROC_MUL_EN
    vt[9]  = '{{16'hA3FF,16'hA402,16'h0650,H,H,H,H,H},                                       1'b0,10'h0,  16'h0,    16'hFFFE, 4'b0110,10'h003,0};
`else
    vt[9]  = '{{16'hA3FF,16'hA402,16'h0650,H,H,H,H,H},                                       1'b0,10'h0,  16'h0,    16'h0002, 4'b0000,10'h003,0};
`endif
    vt[10] = '{{16'hE010,16'hD3FF,H,H,H,H,H,H},                                              1'b1,10'h3FF,16'hAC00, 16'h0000, 4'b1000,10'h010,0};
    vt[11] = '{{16'hA205,16'h9440,H,H,H,H,H,H},                                              1'b0,10'h0,  16'h0,    16'h0002, 4'b0010,10'h002,0};

    // Reset values straight out of reset.
    load_reset(vt[0]);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_flags", 32'({zero, negative, carry, overflow}), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_rre", 32'(ram_read_en), 32'h0);
    chk("rst_slv", 32'(store_loaded_val), 32'h0);

    for (int i = 0; i < 12; i++) begin
      load_reset(vt[i]);
      run_to_halt(to);
      chk($sformatf("v%0d_timeout", i), 32'(to), 32'h0);
      chk($sformatf("v%0d_result", i), 32'(result), 32'(vt[i].er));
      chk($sformatf("v%0d_flags", i), 32'({zero, negative, carry, overflow}), 32'(vt[i].ef));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vt[i].epc));
      chk($sformatf("v%0d_slv_cycles", i), 32'(slv_cnt), 32'(vt[i].eslv));
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_pc_frozen", i), 32'(pc), 32'(vt[i].epc));
      chk($sformatf("v%0d_rre_halted", i), 32'(ram_read_en), 32'h0);
    end

    // Reset asserted while the ADD at address 2 is in EXEC.
    load_reset(vt[0]);
    @(negedge clk) start = 1'b1;
    k = 0;
    while (!(ram_read_en && pc == 10'd2) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_reach_fetch2", 32'(k < 100), 32'h1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_pre_result", 32'(result), 32'h0003);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("midrst_result", 32'(result), 32'h0);
    chk("midrst_flags", 32'({zero, negative, carry, overflow}), 32'h0);
    chk("midrst_pc", 32'(pc), 32'h0);
    chk("midrst_rre", 32'(ram_read_en), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    fetches = 0;
    repeat (6) begin
      @(negedge clk);
      if (ram_read_en) fetches++;
    end
    chk("midrst_idle_no_fetch", 32'(fetches), 32'h0);
    chk("midrst_result_after", 32'(result), 32'h0);
    chk("midrst_pc_after", 32'(pc), 32'h0);

    // DECODE must wait while data_vld is low.
    load_reset(vt[0]);
    block = 1'b1;
    @(negedge clk) start = 1'b1;
    k = 0;
    while (!ram_read_en && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("stall_first_fetch", 32'(k < 50), 32'h1);
    repeat (6) @(negedge clk);
    chk("stall_pc", 32'(pc), 32'h0);
    chk("stall_rre", 32'(ram_read_en), 32'h0);
    chk("stall_result", 32'(result), 32'h0);
    block = 1'b0;
    run_to_halt(to);
    chk("stall_timeout", 32'(to), 32'h0);
    chk("stall_final_result", 32'(result), 32'h0008);
    chk("stall_final_pc", 32'(pc), 32'h003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
